// File: rtl/back_icon_controller_rr_if.sv
// rtl/back_icon_controller_rr_if.sv - dispatch/grant/ack bundle between front-end, controller and backend
interface back_icon_controller_rr_if #(
  parameter int CH = 4,
  parameter int NR = 8,
  parameter int AW = 8
);
  logic [CH-1:0][AW-1:0] dispatch_addr_i;
  logic [CH-1:0][NR-1:0] dispatch_rlist_i;
  logic [CH-1:0]         dispatch_valid_i;
  logic [CH-1:0]         dispatch_ready_o;
  logic [CH-1:0][AW-1:0] src_addrs_o;
  logic [CH-1:0][NR-1:0] receiver_lists_o;
  logic [CH-1:0][NR-1:0] success_lists_i;
  logic                  busy_o;

  modport slave (
    input  dispatch_addr_i, dispatch_rlist_i, dispatch_valid_i, success_lists_i,
    output dispatch_ready_o, src_addrs_o, receiver_lists_o, busy_o
  );

  modport master (
    output dispatch_addr_i, dispatch_rlist_i, dispatch_valid_i, success_lists_i,
    input  dispatch_ready_o, src_addrs_o, receiver_lists_o, busy_o
  );
endinterface

// File: rtl/back_icon_controller_rr.sv
// rtl/back_icon_controller_rr.sv - per-channel instruction FIFOs with rotating-priority receiver arbitration
module back_icon_controller_rr #(
  parameter int NUM_ICON_CHANNELS = 4,
  parameter int NUM_RECEIVERS     = 8,
  parameter int ADDR_W            = 8,
  parameter int LOG2_QUEUE_LENGTH = 2,
  parameter int ROUND_ROBIN       = 1
) (
  input  logic clk,
  input  logic reset,
  back_icon_controller_rr_if.slave bus
);
  localparam int CH    = NUM_ICON_CHANNELS;
  localparam int NR    = NUM_RECEIVERS;
  localparam int IW    = LOG2_QUEUE_LENGTH;
  localparam int DEPTH = 1 << IW;
  localparam int PW    = IW + 1;
  localparam int RRW   = (CH > 1) ? $clog2(CH) : 1;

  logic [ADDR_W-1:0] addr_mem_q  [CH][DEPTH];
  logic [NR-1:0]     rlist_mem_q [CH][DEPTH];
  logic [PW-1:0]     wr_ptr_q [CH], wr_ptr_d [CH];
  logic [PW-1:0]     rd_ptr_q [CH], rd_ptr_d [CH];
  logic [NR-1:0]     delivered_q [CH], delivered_d [CH];
  logic [RRW-1:0]    rr_ptr_q, rr_ptr_d;

  logic [CH-1:0]     empty, full, push, pop;
  logic [NR-1:0]     head_rlist [CH], pending [CH], grant [CH], eff_succ [CH];
  logic [ADDR_W-1:0] head_addr [CH];
  logic [NR-1:0]     taken;
  logic              conflict;

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      empty[c]      = (wr_ptr_q[c] == rd_ptr_q[c]);
      full[c]       = ((wr_ptr_q[c] - rd_ptr_q[c]) == PW'(DEPTH));
      head_addr[c]  = addr_mem_q[c][rd_ptr_q[c][IW-1:0]];
      head_rlist[c] = rlist_mem_q[c][rd_ptr_q[c][IW-1:0]];
      pending[c]    = empty[c] ? '0 : (head_rlist[c] & ~delivered_q[c]);
    end
  end

  // Walk channels from rr_ptr; a bit already taken by a higher-priority channel is a conflict.
  always_comb begin
    grant    = '{default: '0};
    taken    = '0;
    conflict = 1'b0;
    for (int k = 0; k < CH; k++) begin
      int idx;
      idx = int'(rr_ptr_q) + k;
      if (idx >= CH) idx = idx - CH;
      grant[idx] = pending[idx] & ~taken;
      if (|(pending[idx] & taken)) conflict = 1'b1;
      taken = taken | pending[idx];
    end
  end

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      eff_succ[c]    = bus.success_lists_i[c] & grant[c];
      pop[c]         = ~empty[c] &
                       (((delivered_q[c] | eff_succ[c]) & head_rlist[c]) == head_rlist[c]);
      push[c]        = bus.dispatch_valid_i[c] & ~full[c] & ~reset;
      delivered_d[c] = pop[c] ? '0 : (delivered_q[c] | eff_succ[c]);
      wr_ptr_d[c]    = push[c] ? wr_ptr_q[c] + 1'b1 : wr_ptr_q[c];
      rd_ptr_d[c]    = pop[c]  ? rd_ptr_q[c] + 1'b1 : rd_ptr_q[c];
    end
    rr_ptr_d = rr_ptr_q;
    if (ROUND_ROBIN == 0) begin
      rr_ptr_d = '0;
    end else if (conflict) begin
      rr_ptr_d = (int'(rr_ptr_q) == CH - 1) ? '0 : rr_ptr_q + 1'b1;
    end
  end

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      bus.dispatch_ready_o[c] = ~reset & ~full[c];
      bus.src_addrs_o[c]      = (reset | empty[c]) ? '0 : head_addr[c];
      bus.receiver_lists_o[c] = reset ? '0 : grant[c];
    end
    bus.busy_o = ~reset & ~(&empty);
  end

  // Payload storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < CH; c++) begin
        wr_ptr_q[c]    <= '0;
        rd_ptr_q[c]    <= '0;
        delivered_q[c] <= '0;
      end
      rr_ptr_q <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (push[c]) begin
          addr_mem_q[c][wr_ptr_q[c][IW-1:0]]  <= bus.dispatch_addr_i[c];
          rlist_mem_q[c][wr_ptr_q[c][IW-1:0]] <= bus.dispatch_rlist_i[c];
        end
        wr_ptr_q[c]    <= wr_ptr_d[c];
        rd_ptr_q[c]    <= rd_ptr_d[c];
        delivered_q[c] <= delivered_d[c];
      end
      rr_ptr_q <= rr_ptr_d;
    end
  end
endmodule
